// File: rtl/instr_mem_sync.sv
// Registered instruction memory for the IF stage: self-clearing word array with a program-load
// port, 1-cycle fetch latency, stall/flush control and misaligned/out-of-range fault flagging.
module instr_mem_sync #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              fetch_fault,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              init_done
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  clr_cnt;
   logic              ready;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  load_idx;
   logic              fetch_ok;
   logic              load_ok;

   // DEPTH is a power of two, so "idx < DEPTH" reduces to all index bits above IDX_W being zero.
   assign fetch_idx = fetch_addr[IDX_W+1:2];
   assign load_idx  = load_addr[IDX_W+1:2];
   assign fetch_ok  = (fetch_addr[1:0] == 2'b00) && !(|fetch_addr[ADDR_W-1:IDX_W+2]);
   assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && !(|load_addr[ADDR_W-1:IDX_W+2]);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_INIT;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // NOTE: a default assignment first keeps always_comb free of inferred latches.
   always_comb begin
      state_nxt = state;
      if (state == S_INIT && clr_cnt == LAST_IDX) state_nxt = S_READY;
   end

   always_comb begin
      ready = (state == S_READY);
   end

   assign init_done = ready;

   // NOTE: the array has no reset branch; the INIT sweep clears it one word per cycle instead.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!ready)       mem[clr_cnt]  <= '0;
         else if (load_ok) mem[load_idx] <= load_data;
      end
   end

   // Reads sample the array before this edge's load lands, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr       <= '0;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (ready) begin
         if (flush) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
         end else if (!stall) begin
            instr_valid <= fetch_valid;
            fetch_fault <= fetch_valid && !fetch_ok;
            instr       <= (fetch_valid && fetch_ok) ? mem[fetch_idx] : '0;
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: a reference word array predicts each fetch result,
// which is queued when the request is driven and compared one cycle later.
module tb_instr_mem_sync;

   logic        clk;
   logic        rst_n;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        stall;
   logic        flush;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_fault;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        init_done;

   instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .stall       (stall),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_fault (fetch_fault),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .init_done   (init_done)
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        fault;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [64];
   int          n_checks = 0;
   int          n_errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t predict(input logic [31:0] a);
      exp_t e;
      logic ok;
      ok = (a[1:0] == 2'b00) && (a[31:2] < 30'd64);
      e.valid = 1'b1;
      e.fault = !ok;
      e.instr = ok ? model[a[7:2]] : 32'h0;
      return e;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (a[1:0] == 2'b00 && a[31:2] < 30'd64) model[a[7:2]] = d;
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_instr"}, instr, e.instr);
         check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, e.valid});
         check({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, e.fault});
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] a);
      fetch_valid = 1'b1;
      fetch_addr  = a;
      sb.push_back(predict(a));
      step();
      fetch_valid = 1'b0;
      compare(tag);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 1'b0;
      model_write(a, d);
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!init_done && n < 200) begin
         step();
         n++;
      end
      check(tag, n, 32'd64);
   endtask

   initial begin
      rst_n       = 1'b0;
      fetch_valid = 1'b0;
      fetch_addr  = '0;
      stall       = 1'b0;
      flush       = 1'b0;
      load_en     = 1'b0;
      load_addr   = '0;
      load_data   = '0;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;

      // Reset and init sweep; an in-range fetch held high throughout must never be accepted.
      step();
      step();
      check("rst_instr", instr, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      rst_n       = 1'b1;
      fetch_valid = 1'b1;
      fetch_addr  = 32'h4;
      wait_init("init_edges");
      fetch_valid = 1'b0;
      check("init_fetch_valid", {31'd0, instr_valid}, 32'd0);

      // Program load then back-to-back fetches.
      load(32'h0, 32'hE3A00014);
      load(32'h4, 32'hE3A01A01);
      fetch("f00", 32'h0);
      fetch("f04", 32'h4);

      // Misaligned and out-of-range fetches; an idle cycle gives valid=0.
      fetch("mis02", 32'h2);
      fetch("oor100", 32'h100);
      sb.push_back('{instr: 32'h0, valid: 1'b0, fault: 1'b0});
      step();
      compare("idle");

      // Dropped loads: misaligned, and out of range (must not alias onto word 0).
      load(32'hD, 32'h11111111);
      load(32'h100, 32'h22222222);
      fetch("drop_mis", 32'hC);
      fetch("drop_oor", 32'h0);

      // Stall holds outputs while the address moves; flush wins over stall.
      fetch("pre_stall", 32'h4);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_valid = 1'b1;
         fetch_addr  = 32'h10 + 32'(i) * 4;
         step();
         check("stall_instr", instr, 32'hE3A01A01);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
      end
      flush = 1'b1;
      step();
      check("flush_instr", instr, 32'h0);
      check("flush_valid", {31'd0, instr_valid}, 32'd0);
      check("flush_fault", {31'd0, fetch_fault}, 32'd0);
      flush       = 1'b0;
      stall       = 1'b0;
      fetch_valid = 1'b0;

      // Same-edge load and fetch to one word returns the old contents.
      load_en     = 1'b1;
      load_addr   = 32'h8;
      load_data   = 32'hAAAAAAAA;
      fetch_valid = 1'b1;
      fetch_addr  = 32'h8;
      sb.push_back(predict(32'h8));
      step();
      load_en     = 1'b0;
      fetch_valid = 1'b0;
      model_write(32'h8, 32'hAAAAAAAA);
      compare("rf_old");
      fetch("rf_new", 32'h8);

      // Mid-operation reset; loads during INIT must be ignored.
      fetch("pre_rst", 32'h0);
      rst_n = 1'b0;
      step();
      check("rst2_instr", instr, 32'h0);
      check("rst2_valid", {31'd0, instr_valid}, 32'd0);
      check("rst2_init_done", {31'd0, init_done}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) model[i] = 32'h0;
      load_en     = 1'b1;
      load_addr   = 32'h0;
      load_data   = 32'h12345678;
      fetch_valid = 1'b1;
      fetch_addr  = 32'h0;
      wait_init("reinit_edges");
      load_en     = 1'b0;
      fetch_valid = 1'b0;
      check("reinit_valid", {31'd0, instr_valid}, 32'd0);
      fetch("post_rst00", 32'h0);
      fetch("post_rst04", 32'h4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
